// File: rtl/video_row_fetcher.sv
// Fetches one text row of cells from SDRAM into a ping-pong line store, applying the
// hardware-scroll first_row offset; display side reads the other bank with 1-cycle latency.
module video_row_fetcher #(
  parameter int         COLUMNS         = 80,
  parameter int         ROWS            = 51,
  parameter logic [3:0] FIRST_ROW_INDEX = 4'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  register_index,
  input  logic [22:0] register_value,
  input  logic        fetch_request,
  input  logic [5:0]  fetch_y,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        overrun,
  output logic [22:0] rd_address,
  output logic        rd_request,
  output logic [8:0]  rd_burst_length,
  input  logic [31:0] rd_data,
  input  logic        rd_data_valid,
  input  logic        rd_done,
  input  logic [6:0]  buf_index,
  output logic [31:0] buf_data
);

  localparam logic [7:0] COLS_W = 8'(COLUMNS);
  localparam logic [6:0] ROWS_W = 7'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  first_row_q, first_row_d;
  logic [5:0]  phys_row_q, phys_row_d;
  logic [7:0]  count_q, count_d;
  logic        fill_bank_q, fill_bank_d;
  logic        overrun_q, overrun_d;
  logic [31:0] buf_data_q, buf_data_d;

  // Both banks in one array: address bit 7 selects the bank.
  logic [31:0] line_mem [0:255];
  logic        mem_we;
  logic [7:0]  mem_waddr;

  logic [6:0]  y_clamp;
  logic [6:0]  row_sum;
  logic [6:0]  row_wrap;

  logic        unused_reg_bits;
  assign unused_reg_bits = ^{register_value[22:15], register_value[8:0]};

  always_comb begin
    y_clamp  = ({1'b0, fetch_y} >= ROWS_W) ? (ROWS_W - 7'd1) : {1'b0, fetch_y};
    row_sum  = y_clamp + {1'b0, first_row_q};
    row_wrap = (row_sum >= ROWS_W) ? (row_sum - ROWS_W) : row_sum;
  end

  always_comb begin
    state_d     = state_q;
    phys_row_d  = phys_row_q;
    count_d     = count_q;
    fill_bank_d = fill_bank_q;
    mem_we      = 1'b0;
    mem_waddr   = {fill_bank_q, count_q[6:0]};
    first_row_d = (register_index == FIRST_ROW_INDEX) ? register_value[14:9] : first_row_q;
    overrun_d   = overrun_q | (fetch_request && (state_q != S_IDLE));
    buf_data_d  = line_mem[{~fill_bank_q, buf_index}];

    case (state_q)
      S_IDLE: begin
        if (fetch_request) begin
          phys_row_d = 6'(row_wrap);
          count_d    = 8'd0;
          state_d    = S_REQUEST;
        end
      end
      S_REQUEST: begin
        state_d = S_RECEIVE;
      end
      S_RECEIVE: begin
        // Words past COLUMNS are dropped; rd_done ends the fetch regardless of count.
        if (rd_data_valid && (count_q < COLS_W)) begin
          mem_we  = 1'b1;
          count_d = count_q + 8'd1;
        end
        if (rd_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        fill_bank_d = ~fill_bank_q;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      first_row_q <= 6'd0;
      phys_row_q  <= 6'd0;
      count_q     <= 8'd0;
      fill_bank_q <= 1'b0;
      overrun_q   <= 1'b0;
      buf_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      first_row_q <= first_row_d;
      phys_row_q  <= phys_row_d;
      count_q     <= count_d;
      fill_bank_q <= fill_bank_d;
      overrun_q   <= overrun_d;
      buf_data_q  <= buf_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      line_mem[mem_waddr] <= rd_data;
    end
  end

  assign fetch_busy      = (state_q != S_IDLE);
  assign fetch_done      = (state_q == S_DONE);
  assign rd_request      = (state_q == S_REQUEST);
  assign overrun         = overrun_q;
  assign rd_address      = {8'd0, phys_row_q, 9'd0};
  assign rd_burst_length = 9'(COLUMNS);
  assign buf_data        = buf_data_q;

endmodule

// File: tb/tb_video_row_fetcher.sv
// Scoreboard bench for video_row_fetcher: expected SDRAM addresses and line-store reads are queued at stimulus time.
module tb_video_row_fetcher;

  localparam int COLUMNS = 80;

  logic        clk;
  logic        reset_n;
  logic [3:0]  register_index;
  logic [22:0] register_value;
  logic        fetch_request;
  logic [5:0]  fetch_y;
  logic        fetch_busy;
  logic        fetch_done;
  logic        overrun;
  logic [22:0] rd_address;
  logic        rd_request;
  logic [8:0]  rd_burst_length;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_done;
  logic [6:0]  buf_index;
  logic [31:0] buf_data;

  video_row_fetcher #(.COLUMNS(COLUMNS), .ROWS(51), .FIRST_ROW_INDEX(4'd1)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .register_index  (register_index),
    .register_value  (register_value),
    .fetch_request   (fetch_request),
    .fetch_y         (fetch_y),
    .fetch_busy      (fetch_busy),
    .fetch_done      (fetch_done),
    .overrun         (overrun),
    .rd_address      (rd_address),
    .rd_request      (rd_request),
    .rd_burst_length (rd_burst_length),
    .rd_data         (rd_data),
    .rd_data_valid   (rd_data_valid),
    .rd_done         (rd_done),
    .buf_index       (buf_index),
    .buf_data        (buf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;

  logic [22:0] exp_addr_q [$];
  logic [31:0] exp_buf_q [$];
  logic        buf_pend = 1'b0;

  // Reference line store: bank b, cell i lives at b*128+i.
  logic [31:0] model_mem [0:255];
  int          tb_fill = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (fetch_done) done_cnt++;
    if (reset_n && rd_request) begin
      if (exp_addr_q.size() == 0) check("rd_request_unexpected", 32'd1, 32'd0);
      else check("rd_address", 32'(rd_address), 32'(exp_addr_q.pop_front()));
      check("rd_burst_length", 32'(rd_burst_length), 32'(COLUMNS));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (buf_pend) begin
      check("buf_data", buf_data, exp_buf_q.pop_front());
      buf_pend = 1'b0;
    end
  endtask

  task automatic issue_read(input int idx);
    buf_index = 7'(idx);
    exp_buf_q.push_back(model_mem[(1 - tb_fill) * 128 + idx]);
    buf_pend = 1'b1;
  endtask

  task automatic read_cell(input int idx);
    issue_read(idx);
    tick();
  endtask

  // Called at posedge+1 of the request cycle; returns at posedge+1 of D+2 with a read issued.
  task automatic do_fetch(input int y, input int nwords, input logic [31:0] base,
                          input int exp_phys, input int ovr_at, input bit req_in_done,
                          input int rd_idx);
    fetch_request = 1'b1;
    fetch_y       = 6'(y);
    exp_addr_q.push_back({8'd0, 6'(exp_phys), 9'd0});
    tick();
    fetch_request = 1'b0;
    check("busy_t1", 32'(fetch_busy), 32'd1);
    check("rd_request_t1", 32'(rd_request), 32'd1);
    for (int i = 0; i < nwords; i++) begin
      tick();
      rd_data_valid = 1'b1;
      rd_data       = base + 32'(i);
      fetch_request = (i == ovr_at);
      if (i < COLUMNS) model_mem[tb_fill * 128 + i] = base + 32'(i);
    end
    tick();
    rd_data_valid = 1'b0;
    fetch_request = 1'b0;
    rd_done       = 1'b1;
    tick();
    rd_done = 1'b0;
    check("done_d1", 32'(fetch_done), 32'd1);
    check("busy_d1", 32'(fetch_busy), 32'd1);
    fetch_request = req_in_done;
    tick();
    fetch_request = 1'b0;
    check("done_d2", 32'(fetch_done), 32'd0);
    check("busy_d2", 32'(fetch_busy), 32'd0);
    tb_fill = 1 - tb_fill;
    issue_read(rd_idx);
  endtask

  initial begin
    int d0;
    reset_n        = 1'b0;
    register_index = 4'd0;
    register_value = 23'd0;
    fetch_request  = 1'b0;
    fetch_y        = 6'd0;
    rd_data        = 32'd0;
    rd_data_valid  = 1'b0;
    rd_done        = 1'b0;
    buf_index      = 7'd0;
    tick();
    tick();
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rd_request", 32'(rd_request), 32'd0);
    check("rst_rd_address", 32'(rd_address), 32'd0);
    check("rst_burst_len", 32'(rd_burst_length), 32'(COLUMNS));
    check("rst_buf_data", buf_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic fetch: row 3, first_row 0
    do_fetch(3, 80, 32'h100, 3, -1, 1'b0, 5);
    tick();
    check("overrun_clear", 32'(overrun), 32'd0);

    // Scroll wrap: first_row 50, y=2 -> physical row 1
    register_index = 4'd1;
    register_value = 23'(50 << 9);
    tick();
    register_index = 4'd0;
    register_value = 23'd0;
    tick();
    do_fetch(2, 80, 32'h200, 1, -1, 1'b0, 10);
    tick();
    // Register write coincident with request: old first_row (50) applies
    register_index = 4'd1;
    register_value = 23'd0;
    do_fetch(2, 80, 32'h300, 1, -1, 1'b0, 20);
    register_index = 4'd0;
    tick();
    // fetch_y beyond ROWS clamps to 50
    do_fetch(60, 80, 32'h400, 50, -1, 1'b0, 79);
    tick();

    // Overrun during RECEIVE
    d0 = done_cnt;
    do_fetch(0, 80, 32'h500, 0, 20, 1'b0, 40);
    tick();
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_single_done", 32'(done_cnt - d0), 32'd1);

    // Short burst into bank 1: cells 70..79 keep the 0x400 row
    do_fetch(7, 70, 32'h700, 7, -1, 1'b0, 75);
    tick();
    read_cell(69);
    read_cell(79);

    // Long burst into bank 0: words past 79 dropped
    do_fetch(8, 90, 32'h800, 8, -1, 1'b0, 79);
    tick();
    read_cell(0);

    // Ping-pong: back-to-back rows 0 and 1, second accepted at D+2
    do_fetch(0, 80, 32'h900, 0, -1, 1'b0, 7);
    do_fetch(1, 80, 32'hA00, 1 << 0, -1, 1'b0, 7);
    tick();
    read_cell(33);

    // Reset mid-fetch after 10 words
    d0 = done_cnt;
    fetch_request = 1'b1;
    fetch_y       = 6'd5;
    exp_addr_q.push_back({8'd0, 6'd5, 9'd0});
    tick();
    fetch_request = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rd_data_valid = 1'b1;
      rd_data       = 32'hB00 + 32'(i);
      model_mem[tb_fill * 128 + i] = 32'hB00 + 32'(i);
    end
    tick();
    rd_data_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(fetch_busy), 32'd0);
    check("mid_rst_done", 32'(fetch_done), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_rd_request", 32'(rd_request), 32'd0);
    check("mid_rst_rd_address", 32'(rd_address), 32'd0);
    check("mid_rst_burst_len", 32'(rd_burst_length), 32'(COLUMNS));
    check("mid_rst_buf_data", buf_data, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tb_fill = 0;
    tick();
    rd_data_valid = 1'b1;
    rd_data       = 32'hDEAD;
    rd_done       = 1'b1;
    tick();
    rd_data_valid = 1'b0;
    rd_done       = 1'b0;
    check("late_done_ignored", 32'(fetch_done), 32'd0);
    check("late_busy", 32'(fetch_busy), 32'd0);
    tick();
    check("late_no_done_pulse", 32'(done_cnt - d0), 32'd0);

    // Fetch after release; request during DONE cycle is an overrun
    do_fetch(4, 80, 32'hC00, 4, -1, 1'b1, 3);
    tick();
    check("overrun_in_done", 32'(overrun), 32'd1);
    tick();
    tick();
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("total_done_pulses", 32'(done_cnt), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
